// File: rtl/pw_tx_if.sv
// Word handshake between a producer and the pw_tx pulse-width line transmitter.
interface pw_tx_if #(
  parameter int unsigned W      = 8,
  parameter int unsigned DATA_W = 8
);
  logic [W-1:0]      div_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;

  modport master (output div_i, output data_i, output valid_i, input ready_o);
  modport slave  (input div_i, input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/pw_tx.sv
// Pulse-width line transmitter: sync pulses then width-coded data pulses, LSB first.
// Define PW_TX_PARITY_EN to append an even-parity symbol after the data MSB.
module pw_tx #(
  parameter int unsigned W      = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PRE    = 4
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  pw_tx_if.slave   bus,
  output logic     data_o,
  output logic     busy_o
);

  localparam int unsigned IDX_MAX = (PRE > DATA_W + 1) ? PRE : DATA_W + 1;
  localparam int unsigned IDX_W   = $clog2(IDX_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_PAR, S_STOP} state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       cnt_q, cnt_d;
  logic [W-1:0]       t_q, t_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               data_q, data_d;
  logic               ready_q, ready_d;
  logic               busy_q;
  logic [W-1:0]       h_d;
  logic               sym_end;
`ifdef PW_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  // Next-state: symbol counter, symbol index and payload shift register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef PW_TX_PARITY_EN
    par_d   = par_q;
`endif
    sym_end = (cnt_q == t_q - W'(1));
    if (state_q == S_IDLE) begin
      if (bus.valid_i) begin
        state_d = S_PRE;
        cnt_d   = '0;
        idx_d   = '0;
        shift_d = bus.data_i;
        t_d     = (bus.div_i < W'(4)) ? W'(4) : bus.div_i;
`ifdef PW_TX_PARITY_EN
        par_d   = ^bus.data_i;
`endif
      end
    end else if (!sym_end) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = '0;
      case (state_q)
        S_PRE: begin
          if (idx_q == IDX_W'(PRE - 1)) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_DATA: begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef PW_TX_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
`ifdef PW_TX_PARITY_EN
        S_PAR:   state_d = S_STOP;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // High width of the symbol being entered; data_o is registered from it
  always_comb begin
    h_d = '0;
    case (state_d)
      S_PRE:  h_d = t_d >> 1;
      S_DATA: h_d = shift_d[0] ? (t_d - (t_d >> 2)) : (t_d >> 2);
`ifdef PW_TX_PARITY_EN
      S_PAR:  h_d = par_d ? (t_d - (t_d >> 2)) : (t_d >> 2);
`endif
      default: h_d = '0;
    endcase
    data_d  = (cnt_d < h_d);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
`ifdef PW_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= ~ready_d;
`ifdef PW_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign busy_o      = busy_q;
  assign bus.ready_o = ready_q;

endmodule

// File: tb/tb_pw_tx.sv
// Directed bench for pw_tx: pulse timing, clamping, back-to-back, disturbance, reset, parity.
`timescale 1ns/1ps
module tb_pw_tx;
  localparam int W   = 8;
  localparam int DW  = 8;
  localparam int PRE = 4;
`ifdef PW_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NSYM = PRE + DW + P;
  localparam int MAXC = 600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_o, busy_o;

  pw_tx_if #(.W(W), .DATA_W(DW)) bus ();

  pw_tx #(.W(W), .DATA_W(DW), .PRE(PRE)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus),
    .data_o (data_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic tr [0:MAXC];
  logic rd [0:MAXC];
  int rise [0:63];
  int wid  [0:63];
  int nr;

  function automatic int exp_w(input int k, input int t, input logic [7:0] d);
    logic b;
    if (k < PRE) return t / 2;
    if (k < PRE + DW) b = d[k - PRE];
    else b = ^d;
    return b ? (t - t / 4) : (t / 4);
  endfunction

  // Present a word and return right after the accepting edge; cycle 0 is the handshake cycle
  task automatic send(input logic [7:0] div, input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.div_i = div; bus.data_i = d; bus.valid_i = 1'b1;
    @(negedge clk);
    while (bus.ready_o !== 1'b1 && n < 400) begin
      @(negedge clk); n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL handshake_timeout ready_o=%b required 1", bus.ready_o);
    end
    tr[0] = data_o; rd[0] = bus.ready_o;
    @(posedge clk); #1;
    if (!hold) bus.valid_i = 1'b0;
  endtask

  task automatic capture(input int n, input int dist_at, input int drop_at);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      tr[c] = data_o; rd[c] = bus.ready_o;
      if (c == dist_at) begin bus.div_i = 8'd5; bus.data_i = 8'hFF; end
      if (c == drop_at) bus.valid_i = 1'b0;
    end
  endtask

  task automatic extract(input int n);
    int j;
    nr = 0;
    for (int c = 1; c <= n; c++) begin
      if (tr[c] === 1'b1 && tr[c-1] === 1'b0 && nr < 64) begin
        rise[nr] = c;
        j = 0;
        while (c + j <= n && tr[c+j] === 1'b1) j++;
        wid[nr] = j;
        nr++;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (data_o !== 1'b0) begin errors++; $display("FAIL reset_data got %b want 0", data_o); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int f;
    f = (NSYM + 1) * 16;
    send(8'd16, 8'hA5, 1'b0);
    capture(f + 2, -1, -1);
    extract(f + 2);
    checks++; if (nr != NSYM) begin errors++; $display("FAIL basic_count got %0d want %0d", nr, NSYM); end
    for (int k = 0; k < NSYM && k < nr; k++) begin
      checks++; if (rise[k] != 1 + k * 16) begin errors++; $display("FAIL basic_rise%0d got %0d want %0d", k, rise[k], 1 + k * 16); end
      checks++; if (wid[k] != exp_w(k, 16, 8'hA5)) begin errors++; $display("FAIL basic_wid%0d got %0d want %0d", k, wid[k], exp_w(k, 16, 8'hA5)); end
    end
    checks++; if (wid[PRE] != 12 || wid[PRE+1] != 4) begin errors++; $display("FAIL basic_bit01 got %0d,%0d want 12,4", wid[PRE], wid[PRE+1]); end
    for (int c = f - 15; c <= f; c++) begin
      checks++; if (tr[c] !== 1'b0) begin errors++; $display("FAIL basic_stop_low c%0d got %b want 0", c, tr[c]); end
    end
    checks++; if (rd[f] !== 1'b0) begin errors++; $display("FAIL basic_ready_last got %b want 0", rd[f]); end
    checks++; if (rd[f+1] !== 1'b1) begin errors++; $display("FAIL basic_ready_back got %b want 1", rd[f+1]); end
  endtask

  task automatic test_clamp;
    int f;
    f = (NSYM + 1) * 4;
    send(8'd2, 8'h01, 1'b0);
    capture(f + 2, -1, -1);
    extract(f + 2);
    checks++; if (nr != NSYM) begin errors++; $display("FAIL clamp_count got %0d want %0d", nr, NSYM); end
    for (int k = 0; k < NSYM && k < nr; k++) begin
      checks++; if (rise[k] != 1 + k * 4) begin errors++; $display("FAIL clamp_rise%0d got %0d want %0d", k, rise[k], 1 + k * 4); end
      checks++; if (wid[k] != exp_w(k, 4, 8'h01)) begin errors++; $display("FAIL clamp_wid%0d got %0d want %0d", k, wid[k], exp_w(k, 4, 8'h01)); end
    end
    checks++; if (wid[0] != 2 || wid[PRE] != 3 || wid[PRE+1] != 1) begin errors++; $display("FAIL clamp_hand got %0d,%0d,%0d want 2,3,1", wid[0], wid[PRE], wid[PRE+1]); end
    checks++; if (rd[f] !== 1'b0 || rd[f+1] !== 1'b1) begin errors++; $display("FAIL clamp_len got %b%b want 01", rd[f], rd[f+1]); end
  endtask

  task automatic test_back_to_back;
    int f;
    f = (NSYM + 1) * 8;
    send(8'd8, 8'h00, 1'b1);
    bus.data_i = 8'hFF;
    capture(2 * f + 3, -1, f + 2);
    extract(2 * f + 3);
    checks++; if (nr != 2 * NSYM) begin errors++; $display("FAIL b2b_count got %0d want %0d", nr, 2 * NSYM); end
    checks++; if (rd[f+1] !== 1'b1 || rd[f+2] !== 1'b0) begin errors++; $display("FAIL b2b_ready got %b%b want 10", rd[f+1], rd[f+2]); end
    if (nr == 2 * NSYM) begin
      checks++; if (rise[NSYM] != f + 2) begin errors++; $display("FAIL b2b_start got %0d want %0d", rise[NSYM], f + 2); end
      for (int k = 0; k < NSYM; k++) begin
        checks++; if (wid[k] != exp_w(k, 8, 8'h00)) begin errors++; $display("FAIL b2b_wid_a%0d got %0d want %0d", k, wid[k], exp_w(k, 8, 8'h00)); end
        checks++; if (wid[NSYM+k] != exp_w(k, 8, 8'hFF)) begin errors++; $display("FAIL b2b_wid_b%0d got %0d want %0d", k, wid[NSYM+k], exp_w(k, 8, 8'hFF)); end
      end
      for (int k = PRE; k < PRE + DW; k++) begin
        checks++; if (wid[NSYM+k] != 6) begin errors++; $display("FAIL b2b_ones%0d got %0d want 6", k, wid[NSYM+k]); end
      end
    end
    repeat (f + 4) @(negedge clk);
  endtask

  task automatic test_disturb;
    int f;
    f = (NSYM + 1) * 16;
    send(8'd16, 8'hA5, 1'b0);
    capture(f + 2, 100, -1);
    extract(f + 2);
    checks++; if (nr != NSYM) begin errors++; $display("FAIL dist_count got %0d want %0d", nr, NSYM); end
    for (int k = 0; k < NSYM && k < nr; k++) begin
      checks++; if (rise[k] != 1 + k * 16) begin errors++; $display("FAIL dist_rise%0d got %0d want %0d", k, rise[k], 1 + k * 16); end
      checks++; if (wid[k] != exp_w(k, 16, 8'hA5)) begin errors++; $display("FAIL dist_wid%0d got %0d want %0d", k, wid[k], exp_w(k, 16, 8'hA5)); end
    end
    checks++; if (rd[f+1] !== 1'b1) begin errors++; $display("FAIL dist_ready got %b want 1", rd[f+1]); end
  endtask

  task automatic test_reset_mid;
    int f;
    f = (NSYM + 1) * 8;
    send(8'd8, 8'h3C, 1'b0);
    capture(60, -1, -1);
    checks++; if (tr[60] !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b want 1", tr[60]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (data_o !== 1'b0) begin errors++; $display("FAIL rmid_data got %b want 0", data_o); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", bus.ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy_o); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(8'd8, 8'h3C, 1'b0);
    capture(f + 2, -1, -1);
    extract(f + 2);
    checks++; if (nr != NSYM) begin errors++; $display("FAIL rnew_count got %0d want %0d", nr, NSYM); end
    for (int k = 0; k < NSYM && k < nr; k++) begin
      checks++; if (rise[k] != 1 + k * 8) begin errors++; $display("FAIL rnew_rise%0d got %0d want %0d", k, rise[k], 1 + k * 8); end
      checks++; if (wid[k] != exp_w(k, 8, 8'h3C)) begin errors++; $display("FAIL rnew_wid%0d got %0d want %0d", k, wid[k], exp_w(k, 8, 8'h3C)); end
    end
    checks++; if (rd[f+1] !== 1'b1) begin errors++; $display("FAIL rnew_ready got %b want 1", rd[f+1]); end
  endtask

`ifdef PW_TX_PARITY_EN
  task automatic test_parity;
    send(8'd16, 8'h07, 1'b0);
    capture(226, -1, -1);
    extract(226);
    checks++; if (nr != NSYM || wid[PRE+DW] != 12) begin errors++; $display("FAIL par07 count %0d wid %0d want %0d,12", nr, wid[PRE+DW], NSYM); end
    checks++; if (rd[224] !== 1'b0 || rd[225] !== 1'b1) begin errors++; $display("FAIL par07_len got %b%b want 01", rd[224], rd[225]); end
    send(8'd16, 8'h03, 1'b0);
    capture(226, -1, -1);
    extract(226);
    checks++; if (nr != NSYM || wid[PRE+DW] != 4) begin errors++; $display("FAIL par03 count %0d wid %0d want %0d,4", nr, wid[PRE+DW], NSYM); end
  endtask
`endif

  initial begin
    bus.valid_i = 1'b0;
    bus.div_i   = '0;
    bus.data_i  = '0;
    tr[0] = 1'b0; rd[0] = 1'b1;
    test_reset;
    test_basic;
    test_clamp;
    test_back_to_back;
    test_disturb;
    test_reset_mid;
`ifdef PW_TX_PARITY_EN
    test_parity;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
